// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants and lock state encoding,
// shared by the VGA output stage and the receive-side sync decoder.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;

  localparam int VGA_H_TOTAL =
    VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL =
    VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam logic VGA_SYNC_ACTIVE = 1'b0;
  localparam int   VGA_LOCK_FRAMES = 2;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: registers one sync input (2 stages), flags its assertion
// edge and runs the axis counter. Ports: clock, reset_n, sync_raw,
// advance (count enable), assert_edge, count (stage-2 sample), pos (stage-1).
module vga_sync_edge #(
  parameter int   W      = 11,
  parameter logic ACTIVE = 1'b0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         sync_raw,
  input  logic         advance,
  output logic         assert_edge,
  output logic [W-1:0] count,
  output logic [W-1:0] pos
);

  localparam logic [W-1:0] MAX = '1;

  logic s1;
  logic s2;

  assign assert_edge = (s1 == ACTIVE) && (s2 != ACTIVE);

  // pos is the position of the sample now in stage 1; count trails it by
  // one sample, so at an edge count still holds the last position of the
  // previous line/frame.
  always_comb begin
    pos = count;
    if (assert_edge)
      pos = '0;
    else if (advance && (count != MAX))
      pos = count + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= ~ACTIVE;
      s2    <= ~ACTIVE;
      count <= '0;
    end else begin
      s1    <= sync_raw;
      s2    <= s1;
      count <= pos;
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates from VGA sync/RGB, checks
// line/frame timing, tracks lock and presents decoded pixels 2 clocks late.
// Ports: clock, reset_n, vga_hsync, vga_vsync, R/G/B in; pixel_valid,
// x_pos, y_pos, pix_R/G/B, frame_start, locked, timing_error out.
// Optional VGA_SYNC_DECODER_CHECKSUM_EN adds frame_checksum/checksum_valid.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = VGA_H_ACTIVE,
  parameter int   H_FRONT     = VGA_H_FRONT,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BACK      = VGA_H_BACK,
  parameter int   V_ACTIVE    = VGA_V_ACTIVE,
  parameter int   V_FRONT     = VGA_V_FRONT,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BACK      = VGA_V_BACK,
  parameter logic SYNC_ACTIVE = VGA_SYNC_ACTIVE,
  parameter int   LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic [7:0]  R,
  input  logic [7:0]  G,
  input  logic [7:0]  B,
  output logic        pixel_valid,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [7:0]  pix_R,
  output logic [7:0]  pix_G,
  output logic [7:0]  pix_B,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_error
`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
  ,
  output logic [31:0] frame_checksum,
  output logic        checksum_valid
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_START = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_END   = 11'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [7:0]  LOCK_LAST = 8'(LOCK_FRAMES - 1);

  logic        h_edge;
  logic        v_edge;
  logic [10:0] hcount;
  logic [10:0] hpos;
  logic [9:0]  vcount;
  logic [9:0]  vpos;
  logic [23:0] rgb;

  lock_state_t state;
  logic [7:0]  good_frames;
  logic        h_seen;
  logic        v_seen;

  logic        line_err;
  logic        frame_err;
  logic        err;
  logic        in_win;
  logic        show;
  logic        origin;
  logic [9:0]  x_next;
  logic [9:0]  y_next;

  vga_sync_edge #(
    .W      (11),
    .ACTIVE (SYNC_ACTIVE)
  ) u_h (
    .clock       (clock),
    .reset_n     (reset_n),
    .sync_raw    (vga_hsync),
    .advance     (1'b1),
    .assert_edge (h_edge),
    .count       (hcount),
    .pos         (hpos)
  );

  // Lines are counted on hsync edges; a vsync edge on the same sample
  // wins and restarts the frame at line 0.
  vga_sync_edge #(
    .W      (10),
    .ACTIVE (SYNC_ACTIVE)
  ) u_v (
    .clock       (clock),
    .reset_n     (reset_n),
    .sync_raw    (vga_vsync),
    .advance     (h_edge),
    .assert_edge (v_edge),
    .count       (vcount),
    .pos         (vpos)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      rgb <= '0;
    else
      rgb <= {R, G, B};
  end

  // At an edge the counter still holds the last index of the previous
  // line/frame, so a correct length shows up as TOTAL-1.
  assign line_err  = h_edge && h_seen && (hcount != H_LAST);
  assign frame_err = v_edge && v_seen && (vcount != V_LAST);
  assign err       = line_err || frame_err;

  assign in_win = (hpos >= H_START) && (hpos <= H_END)
               && (vpos >= V_START) && (vpos <= V_END);

  // An error sample already counts as unlocked so pixel_valid drops
  // together with locked.
  assign show   = (state == LOCKED) && !err && in_win;
  assign x_next = 10'(hpos - H_START);
  assign y_next = vpos - V_START;
  assign origin = (x_next == '0) && (y_next == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= SEARCH;
      good_frames  <= '0;
      locked       <= 1'b0;
      timing_error <= 1'b0;
      h_seen       <= 1'b0;
      v_seen       <= 1'b0;
    end else begin
      timing_error <= err;
      if (h_edge)
        h_seen <= 1'b1;
      if (v_edge)
        v_seen <= 1'b1;
      unique case (1'b1)
        (state == SEARCH): begin
          if (v_edge) begin
            state       <= CHECK;
            good_frames <= '0;
          end
        end
        (state == CHECK): begin
          if (err) begin
            good_frames <= '0;
          end else if (v_edge) begin
            if (good_frames == LOCK_LAST) begin
              state       <= LOCKED;
              locked      <= 1'b1;
              good_frames <= '0;
            end else begin
              good_frames <= good_frames + 8'd1;
            end
          end
        end
        (state == LOCKED): begin
          if (err) begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        end
        default: begin
          state       <= SEARCH;
          locked      <= 1'b0;
          good_frames <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
      pix_R       <= '0;
      pix_G       <= '0;
      pix_B       <= '0;
    end else begin
      pixel_valid <= show;
      frame_start <= show && origin;
      if (show) begin
        x_pos <= x_next;
        y_pos <= y_next;
        pix_R <= rgb[23:16];
        pix_G <= rgb[15:8];
        pix_B <= rgb[7:0];
      end
    end
  end

`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
  logic [31:0] acc;

  // The frame sum is published at the vsync edge that closes a frame
  // which was fully decoded under lock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc            <= '0;
      frame_checksum <= '0;
      checksum_valid <= 1'b0;
    end else begin
      checksum_valid <= 1'b0;
      if (show) begin
        if (origin)
          acc <= {8'd0, rgb};
        else
          acc <= acc + {8'd0, rgb};
      end
      if (v_edge && (state == LOCKED)) begin
        frame_checksum <= acc;
        checksum_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed bench for vga_sync_decoder on a reduced
// 25x13 raster (16x8 visible) so a frame is only 325 clocks.
module tb_vga_sync_decoder;

  localparam int HA = 16;
  localparam int HF = 2;
  localparam int HS = 4;
  localparam int HB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VA = 8;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VT = VA + VF + VS + VB;
  localparam int NPIX = HA * VA;
  localparam logic [23:0] C0 = 24'h0A0B0C;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       vga_hsync = 1'b1;
  logic       vga_vsync = 1'b1;
  logic [7:0] R = '0;
  logic [7:0] G = '0;
  logic [7:0] B = '0;
  logic       pixel_valid;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [7:0] pix_R;
  logic [7:0] pix_G;
  logic [7:0] pix_B;
  logic       frame_start;
  logic       locked;
  logic       timing_error;
`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
  logic [31:0] frame_checksum;
  logic        checksum_valid;
`endif

  int passed = 0;
  int total = 0;
  int pv_cnt = 0;
  int fs_cnt = 0;
  int te_cnt = 0;
  int te_locked = 0;

  vga_sync_decoder #(
    .H_ACTIVE    (HA),
    .H_FRONT     (HF),
    .H_SYNC      (HS),
    .H_BACK      (HB),
    .V_ACTIVE    (VA),
    .V_FRONT     (VF),
    .V_SYNC      (VS),
    .V_BACK      (VB),
    .SYNC_ACTIVE (1'b0),
    .LOCK_FRAMES (2)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .vga_hsync    (vga_hsync),
    .vga_vsync    (vga_vsync),
    .R            (R),
    .G            (G),
    .B            (B),
    .pixel_valid  (pixel_valid),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .pix_R        (pix_R),
    .pix_G        (pix_G),
    .pix_B        (pix_B),
    .frame_start  (frame_start),
    .locked       (locked),
    .timing_error (timing_error)
`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
    ,
    .frame_checksum (frame_checksum),
    .checksum_valid (checksum_valid)
`endif
  );

  always #20 clock = ~clock;

  always @(negedge clock) begin
    if (pixel_valid)
      pv_cnt <= pv_cnt + 1;
    if (frame_start)
      fs_cnt <= fs_cnt + 1;
    if (timing_error)
      te_cnt <= te_cnt + 1;
    if (timing_error && locked)
      te_locked <= te_locked + 1;
  end

  task automatic drive_at(input int v, input int h, input logic [23:0] c);
    vga_hsync = (h < HS) ? 1'b0 : 1'b1;
    vga_vsync = (v < VS) ? 1'b0 : 1'b1;
    {R, G, B} = c;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    vga_hsync = 1'b1;
    vga_vsync = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_line(input int v, input int h0, input int h1,
                           input logic [23:0] c);
    for (int h = h0; h < h1; h++)
      drive_at(v, h, c);
  endtask

  task automatic send_lines(input int v0, input int v1, input logic [23:0] c);
    for (int v = v0; v <= v1; v++)
      send_line(v, 0, HT, c);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    idle(3);
    total++;
    if ({pixel_valid, frame_start, locked, timing_error} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000",
               {pixel_valid, frame_start, locked, timing_error});
    else passed++;
    total++;
    if ({x_pos, y_pos, pix_R, pix_G, pix_B} !== 44'd0)
      $display("FAIL reset_data: got %h want 0",
               {x_pos, y_pos, pix_R, pix_G, pix_B});
    else passed++;
    reset_n = 1'b1;
    idle(5);
    total++;
    if (locked !== 1'b0)
      $display("FAIL reset_idle_lock: got %b want 0", locked);
    else passed++;
  endtask

  task automatic test_lock;
    int p0, f0, t0;
    p0 = pv_cnt;
    t0 = te_cnt;
    send_lines(0, VT - 1, C0);
    send_lines(0, VT - 1, C0);
    total++;
    if (locked !== 1'b0)
      $display("FAIL lock_early: got %b want 0", locked);
    else passed++;
    total++;
    if (pv_cnt - p0 != 0)
      $display("FAIL unlocked_pixels: got %0d want 0", pv_cnt - p0);
    else passed++;
    drive_at(0, 0, C0);
    total++;
    if (locked !== 1'b0)
      $display("FAIL lock_edge3_pre: got %b want 0", locked);
    else passed++;
    drive_at(0, 1, C0);
    total++;
    if (locked !== 1'b1)
      $display("FAIL lock_edge3: got %b want 1", locked);
    else passed++;
    p0 = pv_cnt;
    f0 = fs_cnt;
    send_line(0, 2, HT, C0);
    send_lines(1, VT - 1, C0);
    total++;
    if (pv_cnt - p0 != NPIX)
      $display("FAIL frame3_pixels: got %0d want %0d", pv_cnt - p0, NPIX);
    else passed++;
    total++;
    if (fs_cnt - f0 != 1)
      $display("FAIL frame3_start: got %0d want 1", fs_cnt - f0);
    else passed++;
    total++;
    if (te_cnt - t0 != 0)
      $display("FAIL nominal_errors: got %0d want 0", te_cnt - t0);
    else passed++;
  endtask

  task automatic test_pixel;
    int f0;
    f0 = fs_cnt;
    send_lines(0, VS + VB - 1, C0);
    send_line(VS + VB, 0, HS + HB, C0);
    drive_at(VS + VB, HS + HB, 24'h123456);
    total++;
    if ({pix_R, pix_G, pix_B} !== C0)
      $display("FAIL pix_latency_1clk: got %h want %h",
               {pix_R, pix_G, pix_B}, C0);
    else passed++;
    total++;
    if (x_pos !== 10'(HA - 1) || y_pos !== 10'(VA - 1))
      $display("FAIL pos_hold: got %0d,%0d want %0d,%0d",
               x_pos, y_pos, HA - 1, VA - 1);
    else passed++;
    drive_at(VS + VB, HS + HB + 1, C0);
    total++;
    if ({pix_R, pix_G, pix_B} !== 24'h123456)
      $display("FAIL pix_origin: got %h want 123456", {pix_R, pix_G, pix_B});
    else passed++;
    total++;
    if (x_pos !== 10'd0 || y_pos !== 10'd0 || pixel_valid !== 1'b1)
      $display("FAIL origin_pos: got x=%0d y=%0d v=%b want 0 0 1",
               x_pos, y_pos, pixel_valid);
    else passed++;
    total++;
    if (frame_start !== 1'b1)
      $display("FAIL frame_start_pulse: got %b want 1", frame_start);
    else passed++;
    drive_at(VS + VB, HS + HB + 2, C0);
    total++;
    if (frame_start !== 1'b0 || x_pos !== 10'd1 ||
        {pix_R, pix_G, pix_B} !== C0)
      $display("FAIL second_pixel: got fs=%b x=%0d pix=%h want 0 1 %h",
               frame_start, x_pos, {pix_R, pix_G, pix_B}, C0);
    else passed++;
    send_line(VS + VB, HS + HB + 3, HT, C0);
    send_lines(VS + VB + 1, VT - 1, C0);
    total++;
    if (fs_cnt - f0 != 1)
      $display("FAIL frame4_start: got %0d want 1", fs_cnt - f0);
    else passed++;
  endtask

  task automatic test_checksum;
    drive_at(0, 0, 24'h000001);
    drive_at(0, 1, 24'h000001);
`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
    total++;
    if (checksum_valid !== 1'b1 ||
        frame_checksum !== 32'd127 * 32'h0A0B0C + 32'h123456)
      $display("FAIL checksum_mixed: got v=%b sum=%0d want 1 %0d",
               checksum_valid, frame_checksum,
               32'd127 * 32'h0A0B0C + 32'h123456);
    else passed++;
`endif
    drive_at(0, 2, 24'h000001);
`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
    total++;
    if (checksum_valid !== 1'b0)
      $display("FAIL checksum_pulse_len: got %b want 0", checksum_valid);
    else passed++;
`endif
    send_line(0, 3, HT, 24'h000001);
    send_lines(1, VT - 1, 24'h000001);
    drive_at(0, 0, C0);
    drive_at(0, 1, C0);
`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
    total++;
    if (checksum_valid !== 1'b1 || frame_checksum !== 32'(NPIX))
      $display("FAIL checksum_const: got v=%b sum=%0d want 1 %0d",
               checksum_valid, frame_checksum, NPIX);
    else passed++;
`endif
    send_line(0, 2, HT, C0);
    send_lines(1, VT - 1, C0);
  endtask

  task automatic test_short_line;
    int p0, t0;
    t0 = te_cnt;
    send_lines(0, 5, C0);
    send_line(6, 0, HT - 1, C0);
    drive_at(7, 0, C0);
    total++;
    if (timing_error !== 1'b0 || locked !== 1'b1)
      $display("FAIL short_line_pre: got te=%b lk=%b want 0 1",
               timing_error, locked);
    else passed++;
    drive_at(7, 1, C0);
    total++;
    if (timing_error !== 1'b1 || locked !== 1'b0)
      $display("FAIL short_line_err: got te=%b lk=%b want 1 0",
               timing_error, locked);
    else passed++;
    send_line(7, 2, HT, C0);
    send_lines(8, VT - 1, C0);
    p0 = pv_cnt;
    send_lines(0, VT - 1, C0);
    send_lines(0, VT - 1, C0);
    total++;
    if (te_cnt - t0 != 1 || te_locked != 0)
      $display("FAIL short_line_pulses: got %0d/%0d want 1/0",
               te_cnt - t0, te_locked);
    else passed++;
    total++;
    if (pv_cnt - p0 != 0 || locked !== 1'b0)
      $display("FAIL relock_early: got pv=%0d lk=%b want 0 0",
               pv_cnt - p0, locked);
    else passed++;
    drive_at(0, 0, C0);
    drive_at(0, 1, C0);
    total++;
    if (locked !== 1'b1)
      $display("FAIL relock_line: got %b want 1", locked);
    else passed++;
    send_line(0, 2, HT, C0);
    send_lines(1, VT - 1, C0);
  endtask

  task automatic test_short_frame;
    int t0;
    t0 = te_cnt;
    send_lines(0, VT - 2, C0);
    drive_at(0, 0, C0);
    total++;
    if (timing_error !== 1'b0 || locked !== 1'b1)
      $display("FAIL short_frame_pre: got te=%b lk=%b want 0 1",
               timing_error, locked);
    else passed++;
    drive_at(0, 1, C0);
    total++;
    if (timing_error !== 1'b1 || locked !== 1'b0)
      $display("FAIL short_frame_err: got te=%b lk=%b want 1 0",
               timing_error, locked);
    else passed++;
    send_line(0, 2, HT, C0);
    send_lines(1, VT - 1, C0);
    send_lines(0, VT - 1, C0);
    send_lines(0, VT - 1, C0);
    total++;
    if (te_cnt - t0 != 1 || te_locked != 0)
      $display("FAIL short_frame_pulses: got %0d/%0d want 1/0",
               te_cnt - t0, te_locked);
    else passed++;
    drive_at(0, 0, C0);
    drive_at(0, 1, C0);
    total++;
    if (locked !== 1'b1)
      $display("FAIL relock_frame: got %b want 1", locked);
    else passed++;
    send_line(0, 2, HT, C0);
    send_lines(1, VT - 1, C0);
  endtask

  task automatic test_reset_mid;
    int p0, t0;
    send_lines(0, 4, C0);
    send_line(5, 0, 10, C0);
    total++;
    if (pixel_valid !== 1'b1 || x_pos !== 10'd1 || y_pos !== 10'd1)
      $display("FAIL mid_line_pixel: got v=%b x=%0d y=%0d want 1 1 1",
               pixel_valid, x_pos, y_pos);
    else passed++;
    reset_n = 1'b0;
    #1;
    total++;
    if ({pixel_valid, frame_start, locked, timing_error} !== 4'b0)
      $display("FAIL async_reset_flags: got %b want 0000",
               {pixel_valid, frame_start, locked, timing_error});
    else passed++;
    total++;
    if ({x_pos, y_pos, pix_R, pix_G, pix_B} !== 44'd0)
      $display("FAIL async_reset_data: got %h want 0",
               {x_pos, y_pos, pix_R, pix_G, pix_B});
    else passed++;
    send_line(5, 10, 13, C0);
    reset_n = 1'b1;
    p0 = pv_cnt;
    t0 = te_cnt;
    send_line(5, 13, HT, C0);
    send_lines(6, VT - 1, C0);
    send_lines(0, VT - 1, C0);
    send_lines(0, VT - 1, C0);
    total++;
    if (pv_cnt - p0 != 0 || locked !== 1'b0)
      $display("FAIL reset_relock_early: got pv=%0d lk=%b want 0 0",
               pv_cnt - p0, locked);
    else passed++;
    drive_at(0, 0, C0);
    drive_at(0, 1, C0);
    total++;
    if (locked !== 1'b1)
      $display("FAIL reset_relock: got %b want 1", locked);
    else passed++;
    p0 = pv_cnt;
    send_line(0, 2, HT, C0);
    send_lines(1, VT - 1, C0);
    total++;
    if (pv_cnt - p0 != NPIX || te_cnt - t0 != 0)
      $display("FAIL reset_frame: got pv=%0d te=%0d want %0d 0",
               pv_cnt - p0, te_cnt - t0, NPIX);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_lock;
    test_pixel;
    test_checksum;
    test_short_line;
    test_short_frame;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
